// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader placed directly upstream of the core. It takes a
// byte stream over a valid/ready handshake and writes it into instruction
// memory. The stream is framed as:
//
//   length header L | L program words | checksum
//
// Program words are written to instruction memory addresses 0, 1, 2 ... in
// order. Each write appears exactly one cycle after its word is accepted.
// If the checksum matches, start is raised and then held until reset.
// A bad header or a bad checksum parks the loader in ERR with error set.
//
// Parameters:
//   IW   stream / instruction word width. The length header and the checksum
//        also use this width.
//   IMW  instruction memory address width, giving 2^IMW words.
//        IMW must be less than IW.
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       asynchronous, active-high reset
//   in_valid  stream word present on in_data
//   in_data   stream word
//   in_ready  loader can accept a word this cycle (decoded from state)
//   im_we     instruction memory write enable, one-cycle pulse per word
//   im_addr   instruction memory write address
//   im_wdata  instruction memory write data
//   start     core run enable, held high after a good checksum
//   busy      high while in LOAD or CHECK
//   error     sticky error flag
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int IW  = 8,
  parameter int IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [IW-1:0]  in_data,
  output logic           in_ready,
  output logic           im_we,
  output logic [IMW-1:0] im_addr,
  output logic [IW-1:0]  im_wdata,
  output logic           start,
  output logic           busy,
  output logic           error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_e;

  // Largest legal length header. It is representable because IMW < IW.
  localparam logic [IW-1:0] MAX_LEN = IW'(1) << IMW;

  state_e         state_q;
  logic [IW-1:0]  len_q;
  // The word count is kept at full stream width so it can be compared
  // directly with the header. Its value never exceeds MAX_LEN.
  logic [IW-1:0]  count_q;
  logic [IW-1:0]  sum_q;

  logic           im_we_q;
  logic [IMW-1:0] im_addr_q;
  logic [IW-1:0]  im_wdata_q;
  logic           start_q;
  logic           busy_q;
  logic           error_q;

  // Next-value helpers used by the state machine
  logic           accept;
  logic           len_ok;
  logic [IW-1:0]  count_d;
  logic [IW-1:0]  sum_d;
  logic           last_word;

  // in_ready is decoded from the state only, so it never depends on in_valid
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                     (state_q == S_CHECK);
  assign accept    = in_valid && in_ready;
  assign len_ok    = (in_data != '0) && (in_data <= MAX_LEN);
  assign count_d   = count_q + IW'(1);
  // The adder drops its carry, so the checksum is the sum modulo 2^IW
  assign sum_d     = sum_q + in_data;
  assign last_word = (count_d == len_q);

  // NOTE: state and every registered output are written with non-blocking
  // assignments. All of them then update together at the clock edge, and no
  // branch reads a value that was already changed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // Default: no write this cycle. Only an accepted program word raises it.
      im_we_q <= 1'b0;

      if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            if (len_ok) begin
              len_q   <= in_data;
              count_q <= '0;
              sum_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end

          S_LOAD: begin
            im_we_q    <= 1'b1;
            im_addr_q  <= count_q[IMW-1:0];
            im_wdata_q <= in_data;
            count_q    <= count_d;
            sum_q      <= sum_d;
            if (last_word) begin
              state_q <= S_CHECK;
            end
          end

          S_CHECK: begin
            busy_q <= 1'b0;
            if (in_data == sum_q) begin
              start_q <= 1'b1;
              state_q <= S_RUN;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end

          // RUN and ERR never assert in_ready, so they never accept a word
          default: ;
        endcase
      end
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign start    = start_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. Each test is a byte stream held in a
// queue. For every stream, a small reference model works out the framing,
// the expected writes, the checksum and the final status. The bench drives
// the words one at a time and inserts idle gaps between them. Outputs are
// checked one time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int IW  = 8;
  localparam int IMW = 4;
  localparam int CAP = 1 << IMW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [IW-1:0]  in_data;
  logic           in_ready;
  logic           im_we;
  logic [IMW-1:0] im_addr;
  logic [IW-1:0]  im_wdata;
  logic           start;
  logic           busy;
  logic           error;

  int n_checks = 0;
  int n_errors = 0;
  int we_seen  = 0;

  bit [7:0] stream[$];

  prog_loader #(.IW(IW), .IMW(IMW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .start    (start),
    .busy     (busy),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Counts write pulses. Sampling on the falling edge counts each
  // one-cycle pulse exactly once.
  always @(negedge clk) begin
    if (im_we === 1'b1) we_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset is applied away from the clock edge. The outputs must clear
  // immediately, while rst is still high.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_im_we",    32'(im_we),    32'd0);
    check("rst_im_addr",  32'(im_addr),  32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_start",    32'(start),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the current stream. Before each word except the header, it
  // inserts a random number of idle cycles between gap_min and gap_max.
  task automatic run_stream(input int gap_min, input int gap_max);
    int       len;
    bit       hdr_ok;
    int       total;
    int       frame_len;
    bit       ok;
    int       exp_pulses;
    int       we_start;
    bit       exp_we;
    bit [7:0] exp_sum;

    // Reference model of the frame: the header, the writes and the checksum
    len       = int'(stream[0]);
    hdr_ok    = (len >= 1) && (len <= CAP);
    total     = 0;
    if (hdr_ok) begin
      for (int k = 1; k <= len && k < stream.size(); k++) total += int'(stream[k]);
    end
    exp_sum   = 8'(total % 256);
    frame_len = hdr_ok ? len + 2 : 1;
    ok        = hdr_ok && (stream.size() > len + 1) && (stream[len+1] == exp_sum);
    if (!hdr_ok)                   exp_pulses = 0;
    else if (stream.size() - 1 < len) exp_pulses = stream.size() - 1;
    else                           exp_pulses = len;
    we_start  = we_seen;

    for (int i = 0; i < stream.size(); i++) begin
      int gap;
      gap = (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        check("gap_we",   32'(im_we), 32'd0);
        check("gap_busy", 32'(busy),  32'(hdr_ok && i >= 1 && i < frame_len));
      end

      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stream[i];
      check("ready", 32'(in_ready), 32'(i < frame_len));
      @(posedge clk);
      #1;
      exp_we = hdr_ok && (i >= 1) && (i <= len);
      check("we", 32'(im_we), 32'(exp_we));
      if (exp_we) begin
        check("addr",  32'(im_addr),  32'(i - 1));
        check("wdata", 32'(im_wdata), 32'(stream[i]));
      end
      if (i < frame_len - 1) begin
        check("mid_start", 32'(start), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        check("mid_busy",  32'(busy),  32'(hdr_ok));
      end else begin
        check("end_start", 32'(start), 32'(ok));
        check("end_error", 32'(error), 32'(!ok));
        check("end_busy",  32'(busy),  32'd0);
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_we", 32'(im_we), 32'd0);
    @(negedge clk);
    check("pulses", 32'(we_seen - we_start), 32'(exp_pulses));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    do_reset();

    // Good three-word program. Trailing words must be ignored.
    stream = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h9C, 8'hAA, 8'h55};
    run_stream(0, 0);

    // The same program with a bad checksum
    do_reset();
    stream = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h11, 8'h22};
    run_stream(0, 0);

    // Zero-length header
    do_reset();
    stream = '{8'h00, 8'h01, 8'h02};
    run_stream(0, 1);

    // Header one word longer than the memory capacity
    do_reset();
    stream = '{8'h11, 8'h01, 8'h02};
    run_stream(0, 1);

    // Full-capacity load that ends at the top address
    do_reset();
    stream = '{8'h10};
    for (int k = 0; k < CAP; k++) stream.push_back(8'hFF);
    stream.push_back(8'hF0);
    stream.push_back(8'h3C);
    run_stream(0, 0);

    // Gapped stream with three idle cycles between words
    do_reset();
    stream = '{8'h02, 8'hA0, 8'h01, 8'hA1};
    run_stream(3, 3);

    // Reset in the middle of a four-word load, then a fresh load
    do_reset();
    stream = '{8'h04, 8'($urandom), 8'($urandom)};
    run_stream(0, 1);
    do_reset();
    stream = '{8'h01, 8'h7E, 8'h7E};
    run_stream(0, 0);

    // Randomized frames: the length includes bad headers, and the checksum
    // is sometimes corrupted
    for (int t = 0; t < 10; t++) begin
      int       len;
      int       total;
      bit [7:0] cks;
      do_reset();
      len    = int'($urandom_range(17, 0));
      stream = '{8'(len)};
      total  = 0;
      if (len >= 1 && len <= CAP) begin
        for (int k = 0; k < len; k++) begin
          bit [7:0] w;
          w = 8'($urandom);
          total += int'(w);
          stream.push_back(w);
        end
        cks = 8'(total % 256);
        if ($urandom_range(3, 0) == 0) cks = cks + 8'(1 + $urandom_range(254, 0));
        stream.push_back(cks);
      end
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom));
      run_stream(0, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
